// File: rtl/multicycle_cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control FSM.
package multicycle_cpu_ctrl_pkg;

   // Primary opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC   = 4'd3,
      S_MEM_RD = 4'd4,
      S_MEM_WR = 4'd5,
      S_WB_ALU = 4'd6,
      S_WB_MEM = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_TRAP   = 4'd10
   } state_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_XOR = 3'd2,
      ALU_SLT = 3'd3
   } alu_op_e;

   localparam logic [1:0] PC_SRC_SEQ = 2'd0;
   localparam logic [1:0] PC_SRC_BR  = 2'd1;
   localparam logic [1:0] PC_SRC_JMP = 2'd2;
   localparam logic [1:0] PC_SRC_RS  = 2'd3;

   localparam logic [1:0] REG_DST_RT = 2'd0;
   localparam logic [1:0] REG_DST_RD = 2'd1;
   localparam logic [1:0] REG_DST_RA = 2'd2;

   localparam logic [1:0] M2R_ALU = 2'd0;
   localparam logic [1:0] M2R_MEM = 2'd1;
   localparam logic [1:0] M2R_PC  = 2'd2;

   localparam logic [1:0] SRCB_RT   = 2'd0;
   localparam logic [1:0] SRCB_FOUR = 2'd1;
   localparam logic [1:0] SRCB_SEXT = 2'd2;
   localparam logic [1:0] SRCB_ZEXT = 2'd3;

   localparam logic [1:0] FAULT_NONE    = 2'd0;
   localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
   localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

   // ALU operation for a legal R-type arithmetic funct
   function automatic alu_op_e funct_alu_op(input logic [5:0] fn);
      case (fn)
         FN_SUB:  funct_alu_op = ALU_SUB;
         FN_SLT:  funct_alu_op = ALU_SLT;
         default: funct_alu_op = ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_cpu_ctrl_if.sv
// Memory request/ready handshake between the control FSM and the memory port.
interface multicycle_cpu_ctrl_if;
   logic mem_req;
   logic mem_we;
   logic iord;
   logic mem_ready;

   modport master (output mem_req, output mem_we, output iord, input mem_ready);
   modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/multicycle_cpu_ctrl_perf_counter.sv
// Free-running enable-gated counter, wraps modulo 2^W.
module multicycle_cpu_ctrl_perf_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count
   always_comb begin
      count_d = count_q;
      if (en) count_d = count_q + W'(1);
   end

   // Count register with synchronous clear
   always_ff @(posedge clk) begin
      if (!reset_n) count_q <= '0;
      else          count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/multicycle_cpu_ctrl.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, stalls on the
// memory handshake, traps on illegal instructions and memory timeouts.
module multicycle_cpu_ctrl
   import multicycle_cpu_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [5:0]            opcode,
   input  logic [5:0]            funct,
   input  logic                  zero,
   multicycle_cpu_ctrl_if.master mem,
   output logic                  ir_we,
   output logic                  pc_we,
   output logic [1:0]            pc_src,
   output logic                  reg_we,
   output logic [1:0]            reg_dst,
   output logic [1:0]            mem_to_reg,
   output logic                  alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic [2:0]            alu_op,
   output logic [3:0]            state,
   output logic                  fault,
   output logic [1:0]            fault_code,
   output logic [CNT_W-1:0]      instr_count,
   output logic [CNT_W-1:0]      cycle_count
);

   localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   state_e            state_q, state_d;
   logic              fault_q, fault_d;
   logic [1:0]        fault_code_q, fault_code_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [WAIT_W:0]   wait_inc;

   logic              mem_req_c, mem_we_c, iord_c, ir_we_c, pc_we_c, reg_we_c, alu_src_a_c;
   logic [1:0]        pc_src_c, reg_dst_c, mem_to_reg_c, alu_src_b_c;
   alu_op_e           alu_op_c;
   logic              retire_c;
   logic              busy_c;

   assign wait_inc = {1'b0, wait_q} + (WAIT_W + 1)'(1);

   // Next-state, datapath controls, timeout and fault capture
   always_comb begin
      state_d      = state_q;
      fault_d      = fault_q;
      fault_code_d = fault_code_q;
      wait_d       = wait_q;
      mem_req_c    = 1'b0;
      mem_we_c     = 1'b0;
      iord_c       = 1'b0;
      ir_we_c      = 1'b0;
      pc_we_c      = 1'b0;
      pc_src_c     = PC_SRC_SEQ;
      reg_we_c     = 1'b0;
      reg_dst_c    = REG_DST_RT;
      mem_to_reg_c = M2R_ALU;
      alu_src_a_c  = 1'b0;
      alu_src_b_c  = SRCB_RT;
      alu_op_c     = ALU_ADD;
      retire_c     = 1'b0;

      case (state_q)
         S_IDLE: state_d = S_FETCH;

         S_FETCH: begin
            mem_req_c   = 1'b1;
            alu_src_b_c = SRCB_FOUR;
            if (mem.mem_ready) begin
               ir_we_c = 1'b1;
               pc_we_c = 1'b1;
               state_d = S_DECODE;
            end
         end

         S_DECODE: begin
            alu_src_b_c = SRCB_SEXT;
            case (opcode)
               OP_RTYPE: begin
                  if (funct == FN_JR)
                     state_d = S_JUMP;
                  else if (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT)
                     state_d = S_EXEC;
                  else begin
                     state_d      = S_TRAP;
                     fault_code_d = FAULT_ILLEGAL;
                  end
               end
               OP_LW, OP_SW, OP_ADDI, OP_XORI: state_d = S_EXEC;
               OP_BNE:                         state_d = S_BRANCH;
               OP_J, OP_JAL:                   state_d = S_JUMP;
               default: begin
                  state_d      = S_TRAP;
                  fault_code_d = FAULT_ILLEGAL;
               end
            endcase
         end

         S_EXEC: begin
            alu_src_a_c = 1'b1;
            case (opcode)
               OP_RTYPE: begin
                  alu_src_b_c = SRCB_RT;
                  alu_op_c    = funct_alu_op(funct);
                  state_d     = S_WB_ALU;
               end
               OP_XORI: begin
                  alu_src_b_c = SRCB_ZEXT;
                  alu_op_c    = ALU_XOR;
                  state_d     = S_WB_ALU;
               end
               OP_LW: begin
                  alu_src_b_c = SRCB_SEXT;
                  state_d     = S_MEM_RD;
               end
               OP_SW: begin
                  alu_src_b_c = SRCB_SEXT;
                  state_d     = S_MEM_WR;
               end
               default: begin
                  alu_src_b_c = SRCB_SEXT;
                  state_d     = S_WB_ALU;
               end
            endcase
         end

         S_MEM_RD: begin
            mem_req_c = 1'b1;
            iord_c    = 1'b1;
            if (mem.mem_ready) state_d = S_WB_MEM;
         end

         S_MEM_WR: begin
            mem_req_c = 1'b1;
            mem_we_c  = 1'b1;
            iord_c    = 1'b1;
            if (mem.mem_ready) begin
               retire_c = 1'b1;
               state_d  = S_FETCH;
            end
         end

         S_WB_ALU: begin
            reg_we_c  = 1'b1;
            reg_dst_c = (opcode == OP_RTYPE) ? REG_DST_RD : REG_DST_RT;
            retire_c  = 1'b1;
            state_d   = S_FETCH;
         end

         S_WB_MEM: begin
            reg_we_c     = 1'b1;
            mem_to_reg_c = M2R_MEM;
            retire_c     = 1'b1;
            state_d      = S_FETCH;
         end

         S_BRANCH: begin
            alu_src_a_c = 1'b1;
            alu_op_c    = ALU_SUB;
            pc_we_c     = ~zero;
            pc_src_c    = PC_SRC_BR;
            retire_c    = 1'b1;
            state_d     = S_FETCH;
         end

         S_JUMP: begin
            pc_we_c  = 1'b1;
            pc_src_c = (opcode == OP_RTYPE) ? PC_SRC_RS : PC_SRC_JMP;
            if (opcode == OP_JAL) begin
               reg_we_c     = 1'b1;
               reg_dst_c    = REG_DST_RA;
               mem_to_reg_c = M2R_PC;
            end
            retire_c = 1'b1;
            state_d  = S_FETCH;
         end

         S_TRAP: state_d = S_TRAP;

         default: state_d = S_IDLE;
      endcase

      // Stall accounting; a same-cycle mem_ready never counts as a stall
      if (MEM_TIMEOUT != 0 && mem_req_c && !mem.mem_ready) begin
         wait_d = wait_inc[WAIT_W-1:0];
         if (wait_inc == (WAIT_W + 1)'(MEM_TIMEOUT)) begin
            state_d      = S_TRAP;
            fault_code_d = FAULT_TIMEOUT;
         end
      end

      if (state_d != state_q) wait_d = '0;
      if (state_d == S_TRAP && state_q != S_TRAP) fault_d = 1'b1;
   end

   // State, fault and wait-counter registers with synchronous clear
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         fault_q      <= 1'b0;
         fault_code_q <= FAULT_NONE;
         wait_q       <= '0;
      end else begin
         state_q      <= state_d;
         fault_q      <= fault_d;
         fault_code_q <= fault_code_d;
         wait_q       <= wait_d;
      end
   end

   assign busy_c = (state_q != S_IDLE) && (state_q != S_TRAP);

   multicycle_cpu_ctrl_perf_counter #(.W(CNT_W)) u_instr_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (retire_c),
      .count   (instr_count)
   );

   multicycle_cpu_ctrl_perf_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (busy_c),
      .count   (cycle_count)
   );

   assign mem.mem_req = mem_req_c;
   assign mem.mem_we  = mem_we_c;
   assign mem.iord    = iord_c;
   assign ir_we       = ir_we_c;
   assign pc_we       = pc_we_c;
   assign pc_src      = pc_src_c;
   assign reg_we      = reg_we_c;
   assign reg_dst     = reg_dst_c;
   assign mem_to_reg  = mem_to_reg_c;
   assign alu_src_a   = alu_src_a_c;
   assign alu_src_b   = alu_src_b_c;
   assign alu_op      = alu_op_c;
   assign state       = state_q;
   assign fault       = fault_q;
   assign fault_code  = fault_code_q;

endmodule

// File: tb/tb_multicycle_cpu_ctrl.sv
// Directed bench for multicycle_cpu_ctrl: per-instruction vector table plus
// hand sequences for reset, memory stalls, illegal opcodes and timeouts.
module tb_multicycle_cpu_ctrl;

   localparam int unsigned CNT_W = 32;

   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_FETCH  = 4'd1;
   localparam logic [3:0] ST_DECODE = 4'd2;
   localparam logic [3:0] ST_MEM_RD = 4'd4;
   localparam logic [3:0] ST_WB_MEM = 4'd7;
   localparam logic [3:0] ST_TRAP   = 4'd10;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [5:0]       opcode, funct;
   logic             zero;
   logic             ir_we, pc_we, reg_we, alu_src_a, fault;
   logic [1:0]       pc_src, reg_dst, mem_to_reg, alu_src_b, fault_code;
   logic [2:0]       alu_op;
   logic [3:0]       state;
   logic [CNT_W-1:0] instr_count, cycle_count;
   logic [17:0]      strobes;

   int tests = 0;
   int fails = 0;

   multicycle_cpu_ctrl_if mif ();

   multicycle_cpu_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .opcode      (opcode),
      .funct       (funct),
      .zero        (zero),
      .mem         (mif.master),
      .ir_we       (ir_we),
      .pc_we       (pc_we),
      .pc_src      (pc_src),
      .reg_we      (reg_we),
      .reg_dst     (reg_dst),
      .mem_to_reg  (mem_to_reg),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .alu_op      (alu_op),
      .state       (state),
      .fault       (fault),
      .fault_code  (fault_code),
      .instr_count (instr_count),
      .cycle_count (cycle_count)
   );

   always #5 clk = ~clk;

   assign strobes = {mif.mem_req, mif.mem_we, mif.iord, ir_we, pc_we, pc_src, reg_we,
                     reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op};

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      int         len;
      logic [3:0] last_st;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       reg_we;
      logic [1:0] reg_dst;
      logic [1:0] m2r;
      logic       mem_we;
      logic [2:0] c3_alu;
      logic [1:0] c3_b;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Hold reset low for two edges, leave the bench at a falling edge
   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      int   stalls;
      int   rd_req;
      bit   done;
      bit   iord_ok;
      logic [3:0] l_st;
      logic l_pc_we, l_reg_we, l_mem_we;
      logic [1:0] l_pc_src, l_reg_dst, l_m2r, c3_b, wb_m2r;
      logic [2:0] c3_alu;

      //         op     fn     z  len st  pcwe pcsrc rwe rdst m2r mwe alu b
      vecs[0]  = '{6'h00, 6'h20, 1'b0, 4, 4'd6, 1'b0, 2'd0, 1'b1, 2'd1, 2'd0, 1'b0, 3'd0, 2'd0};
      vecs[1]  = '{6'h00, 6'h22, 1'b0, 4, 4'd6, 1'b0, 2'd0, 1'b1, 2'd1, 2'd0, 1'b0, 3'd1, 2'd0};
      vecs[2]  = '{6'h00, 6'h2A, 1'b0, 4, 4'd6, 1'b0, 2'd0, 1'b1, 2'd1, 2'd0, 1'b0, 3'd3, 2'd0};
      vecs[3]  = '{6'h08, 6'h00, 1'b0, 4, 4'd6, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 3'd0, 2'd2};
      vecs[4]  = '{6'h0E, 6'h00, 1'b0, 4, 4'd6, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 3'd2, 2'd3};
      vecs[5]  = '{6'h2B, 6'h00, 1'b0, 4, 4'd5, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd0, 2'd2};
      vecs[6]  = '{6'h23, 6'h00, 1'b0, 5, 4'd7, 1'b0, 2'd0, 1'b1, 2'd0, 2'd1, 1'b0, 3'd0, 2'd2};
      vecs[7]  = '{6'h05, 6'h00, 1'b0, 3, 4'd8, 1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0, 3'd1, 2'd0};
      vecs[8]  = '{6'h05, 6'h00, 1'b1, 3, 4'd8, 1'b0, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0, 3'd1, 2'd0};
      vecs[9]  = '{6'h02, 6'h00, 1'b0, 3, 4'd9, 1'b1, 2'd2, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 2'd0};
      vecs[10] = '{6'h03, 6'h00, 1'b0, 3, 4'd9, 1'b1, 2'd2, 1'b1, 2'd2, 2'd2, 1'b0, 3'd0, 2'd0};
      vecs[11] = '{6'h00, 6'h08, 1'b0, 3, 4'd9, 1'b1, 2'd3, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 2'd0};

      reset_n       = 1'b0;
      opcode        = 6'h00;
      funct         = 6'h20;
      zero          = 1'b0;
      mif.mem_ready = 1'b0;

      // Reset state, then reset in the middle of a stalled fetch
      do_reset();
      check("idle_state", 32'(state), 32'(ST_IDLE));
      check("idle_strobes", 32'(strobes), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("fetch_after_release", 32'(state), 32'(ST_FETCH));
      check("fetch_mem_req", 32'(mif.mem_req), 32'd1);
      @(negedge clk);
      check("fetch_cycle_count", cycle_count, 32'd1);
      do_reset();
      check("midfetch_rst_state", 32'(state), 32'(ST_IDLE));
      check("midfetch_rst_strobes", 32'(strobes), 32'd0);
      check("midfetch_rst_cyc", cycle_count, 32'd0);
      check("midfetch_rst_ins", instr_count, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("refetch_state", 32'(state), 32'(ST_FETCH));

      // One instruction per vector with mem_ready tied high
      for (int v = 0; v < 12; v++) begin
         do_reset();
         opcode        = vecs[v].op;
         funct         = vecs[v].fn;
         zero          = vecs[v].z;
         mif.mem_ready = 1'b1;
         reset_n       = 1'b1;
         @(negedge clk);
         check($sformatf("v%0d_fetch", v), 32'(state), 32'(ST_FETCH));
         n = 1; done = 1'b0;
         l_st = '0; l_pc_we = 0; l_reg_we = 0; l_mem_we = 0;
         l_pc_src = '0; l_reg_dst = '0; l_m2r = '0; c3_alu = '0; c3_b = '0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (state == ST_FETCH) begin done = 1'b1; break; end
            n++;
            l_st = state; l_pc_we = pc_we; l_pc_src = pc_src; l_reg_we = reg_we;
            l_reg_dst = reg_dst; l_m2r = mem_to_reg; l_mem_we = mif.mem_we;
            if (n == 3) begin c3_alu = alu_op; c3_b = alu_src_b; end
         end
         check($sformatf("v%0d_done", v), 32'(done), 32'd1);
         check($sformatf("v%0d_len", v), 32'(n), 32'(vecs[v].len));
         check($sformatf("v%0d_last_state", v), 32'(l_st), 32'(vecs[v].last_st));
         check($sformatf("v%0d_pc_we", v), 32'(l_pc_we), 32'(vecs[v].pc_we));
         check($sformatf("v%0d_pc_src", v), 32'(l_pc_src), 32'(vecs[v].pc_src));
         check($sformatf("v%0d_reg_we", v), 32'(l_reg_we), 32'(vecs[v].reg_we));
         check($sformatf("v%0d_reg_dst", v), 32'(l_reg_dst), 32'(vecs[v].reg_dst));
         check($sformatf("v%0d_mem_to_reg", v), 32'(l_m2r), 32'(vecs[v].m2r));
         check($sformatf("v%0d_mem_we", v), 32'(l_mem_we), 32'(vecs[v].mem_we));
         check($sformatf("v%0d_c3_alu_op", v), 32'(c3_alu), 32'(vecs[v].c3_alu));
         check($sformatf("v%0d_c3_alu_b", v), 32'(c3_b), 32'(vecs[v].c3_b));
         check($sformatf("v%0d_instr_count", v), instr_count, 32'd1);
         check($sformatf("v%0d_cycle_count", v), cycle_count, 32'(vecs[v].len));
      end

      // LW with three stall cycles in MEM_RD; the fourth wait cycle completes
      do_reset();
      opcode = 6'h23; funct = 6'h00; mif.mem_ready = 1'b1;
      reset_n = 1'b1;
      @(negedge clk);
      n = 1; stalls = 0; rd_req = 0; iord_ok = 1'b1; done = 1'b0; wb_m2r = '0;
      for (int i = 0; i < 30; i++) begin
         if (state == ST_MEM_RD) begin
            if (mif.mem_req) rd_req++;
            if (!mif.iord) iord_ok = 1'b0;
            mif.mem_ready = (stalls == 3);
            if (stalls < 3) stalls++;
         end else begin
            mif.mem_ready = 1'b1;
         end
         if (state == ST_WB_MEM) wb_m2r = mem_to_reg;
         @(negedge clk);
         if (state == ST_FETCH) begin done = 1'b1; break; end
         n++;
      end
      check("lw_stall_done", 32'(done), 32'd1);
      check("lw_stall_len", 32'(n), 32'd8);
      check("lw_stall_req_cycles", 32'(rd_req), 32'd4);
      check("lw_stall_iord", 32'(iord_ok), 32'd1);
      check("lw_stall_m2r", 32'(wb_m2r), 32'd1);
      check("lw_stall_instr", instr_count, 32'd1);
      check("lw_stall_cycles", cycle_count, 32'd8);

      // Illegal opcode traps from DECODE and the trap is absorbing
      do_reset();
      opcode = 6'h3F; funct = 6'h00; mif.mem_ready = 1'b1;
      reset_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("ill_decode", 32'(state), 32'(ST_DECODE));
      check("ill_no_fault_yet", 32'(fault), 32'd0);
      @(negedge clk);
      check("ill_trap", 32'(state), 32'(ST_TRAP));
      check("ill_fault", 32'(fault), 32'd1);
      check("ill_code", 32'(fault_code), 32'd1);
      check("ill_strobes", 32'(strobes), 32'd0);
      repeat (3) @(negedge clk);
      check("ill_stays_trap", 32'(state), 32'(ST_TRAP));
      check("ill_cyc_frozen", cycle_count, 32'd2);
      check("ill_instr", instr_count, 32'd0);

      // Illegal R-type funct
      do_reset();
      check("rst_clears_fault", 32'(fault), 32'd0);
      check("rst_clears_code", 32'(fault_code), 32'd0);
      opcode = 6'h00; funct = 6'h3F;
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("illfn_trap", 32'(state), 32'(ST_TRAP));
      check("illfn_code", 32'(fault_code), 32'd1);

      // Fetch timeout: four stall cycles, then TRAP with code 2
      do_reset();
      opcode = 6'h00; funct = 6'h20; mif.mem_ready = 1'b0;
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      check("to_still_fetch", 32'(state), 32'(ST_FETCH));
      check("to_no_fault_yet", 32'(fault), 32'd0);
      @(negedge clk);
      check("to_trap", 32'(state), 32'(ST_TRAP));
      check("to_fault", 32'(fault), 32'd1);
      check("to_code", 32'(fault_code), 32'd2);
      check("to_cyc", cycle_count, 32'd4);
      mif.mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("to_cyc_frozen", cycle_count, 32'd4);
      check("to_stays_trap", 32'(state), 32'(ST_TRAP));
      check("to_no_mem_req", 32'(mif.mem_req), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
